// File: rtl/bcd_serial_tens_complementer.sv
// bcd_serial_tens_complementer
//   Serial ten's complementer for an N_DIGITS-wide packed BCD operand. One
//   digit complementer plus a +1 carry stage is reused for every digit,
//   least significant digit first, one digit per clock.
//   Optional: define BCD_COMPL_NINES_MODE_EN to add a 'mode' input
//   (1 = nines complement, 0 = ten's complement), sampled with x on start.
// Ports:
//   clock   - system clock, rising edge
//   reset_  - asynchronous active-low reset
//   soc     - start of conversion (level)
//   mode    - (optional) nines-complement select, sampled at start
//   x       - packed BCD operand, digit i = x[4i+3:4i]
//   eoc     - end of conversion, 1 = idle and z valid
//   z       - packed BCD result
//   cout    - carry out of the MSD (1 only for an all-zero operand)
//   err     - an operand digit > 9 was seen in the last conversion

// One-digit nines complement plus incoming carry. Non-BCD digits yield 4'hF
// and kill the carry so the error stays local to that digit.
module bcd_digit_compl (
  input  logic [3:0] d,
  input  logic       cin,
  output logic [3:0] q,
  output logic       cout,
  output logic       bad
);
  logic [4:0] s;

  always_comb begin
    s    = 5'(4'd9 - d) + 5'(cin);
    bad  = (d > 4'd9);
    q    = s[3:0];
    cout = 1'b0;
    if (bad) begin
      q = 4'hF;
    end else if (s == 5'd10) begin
      q    = 4'h0;
      cout = 1'b1;
    end
  end
endmodule

module bcd_serial_tens_complementer #(
  parameter int N_DIGITS = 4
) (
  input  logic                  clock,
  input  logic                  reset_,
  input  logic                  soc,
`ifdef BCD_COMPL_NINES_MODE_EN
  input  logic                  mode,
`endif
  input  logic [4*N_DIGITS-1:0] x,
  output logic                  eoc,
  output logic [4*N_DIGITS-1:0] z,
  output logic                  cout,
  output logic                  err
);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, CALC, WAIT_SOC} state_t;

  state_t                       state_q, state_d;
  logic [4*N_DIGITS-1:0]        opnd_q;   // shifts right, current digit at [3:0]
  logic [N_DIGITS-1:0][3:0]     z_q;
  logic [IW-1:0]                idx_q;
  logic                         carry_q, cout_q, err_q;
  logic [3:0]                   dig_q;
  logic                         dig_cout, dig_bad;
  logic                         last, start, start_carry;

  bcd_digit_compl u_dig (
    .d    (opnd_q[3:0]),
    .cin  (carry_q),
    .q    (dig_q),
    .cout (dig_cout),
    .bad  (dig_bad)
  );

`ifdef BCD_COMPL_NINES_MODE_EN
  assign start_carry = ~mode;   // no +1 gives the plain nines complement
`else
  assign start_carry = 1'b1;
`endif

  assign last  = (idx_q == IW'(N_DIGITS - 1));
  assign start = (state_q == IDLE) && soc;

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (soc)  state_d = CALC;
      CALC:     if (last) state_d = WAIT_SOC;
      WAIT_SOC: if (!soc) state_d = IDLE;
      default:            state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      opnd_q  <= '0;
      z_q     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (start) begin
      opnd_q  <= x;
      idx_q   <= '0;
      carry_q <= start_carry;
      err_q   <= 1'b0;
    end else if (state_q == CALC) begin
      opnd_q     <= opnd_q >> 4;
      z_q[idx_q] <= dig_q;
      carry_q    <= dig_cout;
      if (dig_bad) err_q <= 1'b1;
      // Index stops at the last digit so it never wraps.
      if (last) cout_q <= dig_cout;
      else      idx_q  <= idx_q + IW'(1);
    end
  end

  assign eoc  = (state_q == IDLE);
  assign z    = z_q;
  assign cout = cout_q;
  assign err  = err_q;
endmodule

// File: tb/tb_bcd_serial_tens_complementer.sv
module tb_bcd_serial_tens_complementer;
  localparam int ND = 4;
`ifdef BCD_COMPL_NINES_MODE_EN
  localparam bit MODE_ON = 1'b1;
`else
  localparam bit MODE_ON = 1'b0;
`endif

  logic            clock = 1'b0;
  logic            reset_ = 1'b0;
  logic            soc = 1'b0;
  logic            mode = 1'b0;
  logic [4*ND-1:0] x = '0;
  logic            eoc, cout, err;
  logic [4*ND-1:0] z;

  int n_chk = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  bcd_serial_tens_complementer #(.N_DIGITS(ND)) dut (
    .clock  (clock),
    .reset_ (reset_),
    .soc    (soc),
`ifdef BCD_COMPL_NINES_MODE_EN
    .mode   (mode),
`endif
    .x      (x),
    .eoc    (eoc),
    .z      (z),
    .cout   (cout),
    .err    (err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pow10(input int p);
    int r = 1;
    for (int i = 0; i < p; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [4*ND-1:0] to_bcd(input int v);
    logic [4*ND-1:0] r = '0;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'((v / pow10(i)) % 10);
    end
    return r;
  endfunction

  // Reference: ten's complement = 10^N - v (mod 10^N), nines = 10^N - 1 - v.
  // A non-BCD digit reads as F; the +1 only propagates through the digits
  // below the lowest bad digit, everything above is a plain nines complement.
  function automatic void model(input logic [4*ND-1:0] xi, input bit nines,
                                output logic [4*ND-1:0] ze, output logic ce,
                                output logic ee);
    int p = ND;
    int vl = 0;
    int m;
    int r;
    logic [3:0] d;
    for (int i = ND - 1; i >= 0; i--) begin
      d = xi[4*i +: 4];
      if (d > 9) p = i;
    end
    ee = (p < ND);
    for (int i = 0; i < p; i++) vl = vl + int'(xi[4*i +: 4]) * pow10(i);
    m  = pow10(p);
    r  = nines ? (m - 1 - vl) : ((m - vl) % m);
    ce = !ee && !nines && (vl == 0);
    ze = to_bcd(r);
    for (int i = p; i < ND; i++) begin
      d = xi[4*i +: 4];
      ze[4*i +: 4] = (d > 9) ? 4'hF : 4'(9 - int'(d));
    end
  endfunction

  // Launch one conversion; soc held for 'hold' edges; x optionally changed
  // 'chg' cycles after the start edge. Checks eoc-low length and results.
  task automatic run(input string tag, input logic [4*ND-1:0] xv, input bit md,
                     input int hold, input int chg, input logic [4*ND-1:0] xnew);
    logic [4*ND-1:0] ze;
    logic ce, ee;
    int lows = 0;
    bit done = 0;
    int exp_lows;
    model(xv, md && MODE_ON, ze, ce, ee);
    exp_lows = (hold > ND + 1) ? hold : ND + 1;
    @(negedge clock);
    soc = 1'b1; x = xv; mode = md;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clock);
      if (c >= hold - 1) soc = 1'b0;
      if (c == chg) x = xnew;
      if (eoc) done = 1;
      else     lows++;
    end
    soc = 1'b0;
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".eoc_low"}, 32'(lows), 32'(exp_lows));
    chk({tag, ".z"}, 32'(z), 32'(ze));
    chk({tag, ".cout"}, 32'(cout), 32'(ce));
    chk({tag, ".err"}, 32'(err), 32'(ee));
  endtask

  task automatic idle_hold(input string tag);
    logic [4*ND-1:0] zk = z;
    for (int i = 0; i < 3; i++) begin
      x = 16'($urandom);
      @(negedge clock);
      chk({tag, ".idle_z"}, 32'(z), 32'(zk));
      chk({tag, ".idle_eoc"}, 32'(eoc), 32'd1);
    end
  endtask

  initial begin
    logic [4*ND-1:0] xr;
    #1;
    chk("rst.eoc", 32'(eoc), 32'd1);
    chk("rst.z", 32'(z), 32'd0);
    chk("rst.cout", 32'(cout), 32'd0);
    chk("rst.err", 32'(err), 32'd0);
    #20 reset_ = 1'b1;

    run("d0123", 16'h0123, 1'b0, 1, -1, '0);
    chk("d0123.z_lit", 32'(z), 32'h9877);
    run("d0000", 16'h0000, 1'b0, 1, -1, '0);
    chk("d0000.cout_lit", 32'(cout), 32'd1);
    run("d5000", 16'h5000, 1'b0, 1, -1, '0);
    idle_hold("d5000");
    run("d9999", 16'h9999, 1'b0, 1, -1, '0);
    chk("d9999.z_lit", 32'(z), 32'h0001);
    run("d00A1", 16'h00A1, 1'b0, 1, -1, '0);
    chk("d00A1.z_lit", 32'(z), 32'h99F9);
    run("d0001", 16'h0001, 1'b0, 1, -1, '0);
    run("hold10", 16'h0123, 1'b0, 10, 2, 16'h4444);
    chk("hold10.z_lit", 32'(z), 32'h9877);

    // Asynchronous reset in the middle of CALC.
    @(negedge clock);
    soc = 1'b1; x = 16'h0456;
    @(posedge clock); #1 soc = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #2 reset_ = 1'b0;
    #1;
    chk("mid_rst.eoc", 32'(eoc), 32'd1);
    chk("mid_rst.z", 32'(z), 32'd0);
    chk("mid_rst.cout", 32'(cout), 32'd0);
    chk("mid_rst.err", 32'(err), 32'd0);
    #1 reset_ = 1'b1;
    run("post_rst", 16'h0123, 1'b0, 1, -1, '0);

`ifdef BCD_COMPL_NINES_MODE_EN
    run("nines", 16'h0123, 1'b1, 1, -1, '0);
    chk("nines.z_lit", 32'(z), 32'h9876);
`endif

    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < ND; i++) begin
        xr[4*i +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                    : 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 9) == 0) xr = '0;
      run($sformatf("rnd%0d", n), xr, 1'($urandom_range(0, 1)),
          int'($urandom_range(1, 8)), int'($urandom_range(0, 4)), 16'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
